fifo: RTL and testbench
=======================

Name: fifo

Overview:
Synchronous single-clock FIFO queue used as the per-port packet-word buffer in the router datapath. Words are written with push and read with pop. full/empty flow-control flags go back to the upstream writer and the downstream reader. Read data is registered, and error pulses flag illegal accesses.

Parameters:
DATA_WIDTH, 32, width of din/dout in bits.
DEPTH, 16, number of storage entries; must be a power of two, minimum 2.
AW, $clog2(DEPTH), pointer/address width (derived; not to be overridden).

Ports:
clock  input  1  single clock; all state updates on rising edge.
reset  input  1  one clock; reset is asynchronous and active-high.
push  input  1  write request; din stored at rising edge if accepted.
pop  input  1  read request; head word moved to dout at rising edge if accepted.
din  input  DATA_WIDTH  write data.
dout  output  DATA_WIDTH  registered read data.
full  output  1  high when DEPTH words are stored.
empty  output  1  high when 0 words are stored.
count  output  AW+1  number of words currently stored (0..DEPTH).
overflow  output  1  one-cycle pulse: push rejected.
underflow  output  1  one-cycle pulse: pop rejected.

Behaviour:
- Reset (async assert, release sampled on the clock): write pointer=0, read pointer=0, count=0, empty=1, full=0, dout=0, overflow=0, underflow=0. Storage contents are don't-care.
- Reset asserted mid-operation: all stored words are discarded immediately and outputs go to reset values without waiting for a clock edge.
- Storage: DEPTH x DATA_WIDTH array, written and read by AW-bit pointers that wrap DEPTH-1 -> 0.
- Accept rules, evaluated on pre-edge state:
  - wr_ok = push && (!full || pop)
  - rd_ok = pop && !empty
- Write: if wr_ok, mem[wptr] <= din and wptr increments.
- Read: if rd_ok, dout <= mem[rptr] and rptr increments. Read latency is 1: data appears on dout after the edge where pop is sampled.
- dout holds its last value when there is no accepted read (including reads attempted while empty).
- No fall-through: a word pushed into an empty FIFO is readable from the next cycle onward.
  - push+pop while empty: write accepted, read rejected (underflow=1), count becomes 1.
- push+pop while full: both accepted, count unchanged, full stays 1; dout gets the oldest word.
- push+pop otherwise: both accepted, count unchanged.
- count <= count + wr_ok - rd_ok.
- empty = (count==0) and full = (count==DEPTH), both registered or derived combinationally from registered count; no glitches relative to clock.
- overflow <= push && !wr_ok; underflow <= pop && !rd_ok. Each is high for exactly the cycle after the rejected request.
- Rejected push leaves memory unchanged. Rejected pop leaves dout and pointers unchanged.
- Order is strict FIFO; no data loss or duplication across pointer wrap.
- din/push/pop are don't-care while reset is asserted.

Test Plan:
1. Reset: assert reset with push=pop=0 -> dout=0, empty=1, full=0, count=0; release, hold two cycles -> unchanged.
2. Fill/drain order: push 10 words (e.g. 0x12153524, 0xC0895E81, ...) on consecutive edges -> count=10, empty=0, full=0. Then pop 10 times -> dout shows the same 10 words in order, one cycle after each pop; empty=1 after the last pop.
3. Full/overflow: push DEPTH=16 words -> full=1 at count 16. A 17th push -> overflow pulses for 1 cycle, count stays 16. Drain -> the 16 original words come out, the 17th is never seen.
4. Underflow: pop when empty -> underflow pulses 1 cycle, dout holds its prior value, count stays 0.
5. Simultaneous: push+pop while empty -> count=1, underflow=1. Push+pop while full with din=0xDEADBEEF -> count stays 16, dout=oldest word, 0xDEADBEEF read last.
6. Wrap and async reset: run 40 push/pop pairs at count≈8 -> order preserved across pointer wrap. Assert reset between edges -> empty=1, count=0, dout=0 immediately.

Source files
------------

// File: rtl/fifo.sv
// Single-clock packet-word FIFO with registered read data (1-cycle pop-to-dout latency).
// Backpressure via full/empty; rejected push/pop raise a one-cycle overflow/underflow pulse.
module fifo #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 16,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic [AW:0]           count,
  output logic                  overflow,
  output logic                  underflow
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]         wptr_q, wptr_d;
  logic [AW-1:0]         rptr_q, rptr_d;
  logic [AW:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_ok, rd_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));

  // A pop frees a slot on the same edge, so push is still accepted when full.
  assign wr_ok = push && (!full || pop);
  assign rd_ok = pop && !empty;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    dout_d      = dout_q;
    overflow_d  = push && !wr_ok;
    underflow_d = pop && !rd_ok;
    if (wr_ok) wptr_d = wptr_q + AW'(1);
    if (rd_ok) begin
      rptr_d = rptr_q + AW'(1);
      dout_d = mem[rptr_q];
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage needs no reset; pointers alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (wr_ok) mem[wptr_q] <= din;
  end

  assign dout      = dout_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo.sv
// Directed bench for fifo: scoreboard queue of pushed words, compared as each accepted pop lands on dout.
module tb_fifo;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          push  = 1'b0;
  logic          pop   = 1'b0;
  logic [DW-1:0] din   = '0;
  logic [DW-1:0] dout;
  logic          full, empty, overflow, underflow;
  logic [AW:0]   count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sb[$];
  logic [DW-1:0] m_dout = '0;

  fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .push(push), .pop(pop), .din(din),
    .dout(dout), .full(full), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_dout"}, 64'(dout), 64'(0));
    chk({tag, "_empty"}, 64'(empty), 64'(1));
    chk({tag, "_full"}, 64'(full), 64'(0));
    chk({tag, "_count"}, 64'(count), 64'(0));
    chk({tag, "_ovf"}, 64'(overflow), 64'(0));
    chk({tag, "_unf"}, 64'(underflow), 64'(0));
  endtask

  // One clock of stimulus; expectations come from the scoreboard state before the edge.
  task automatic step(input logic p, input logic q, input logic [DW-1:0] d);
    logic m_wr, m_rd;
    int   n;
    n    = sb.size();
    m_wr = p && ((n != DEPTH) || q);
    m_rd = q && (n != 0);
    push = p;
    pop  = q;
    din  = d;
    @(posedge clock);
    #1;
    if (m_rd) m_dout = sb.pop_front();
    if (m_wr) sb.push_back(d);
    n = sb.size();
    chk("dout", 64'(dout), 64'(m_dout));
    chk("count", 64'(count), 64'(n));
    chk("empty", 64'(empty), 64'(n == 0));
    chk("full", 64'(full), 64'(n == DEPTH));
    chk("overflow", 64'(overflow), 64'(p && !m_wr));
    chk("underflow", 64'(underflow), 64'(q && !m_rd));
    push = 1'b0;
    pop  = 1'b0;
  endtask

  logic [DW-1:0] words [10] = '{32'h12153524, 32'hC0895E81, 32'h8484D609, 32'hB1F05663,
                                32'h06B97B0D, 32'h46DF998D, 32'hB2C28465, 32'h89375212,
                                32'h00F3E301, 32'h06D7CD0D};

  initial begin
    // Reset held: state must be at reset values before and after a clock edge.
    #2;
    chk_reset_state("rst_async");
    @(posedge clock);
    #1;
    chk_reset_state("rst_edge");
    reset = 1'b0;
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);

    // Fill and drain ten words.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, words[i]);
    chk("fill10_count", 64'(count), 64'(10));
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, '0);
    chk("drain10_last", 64'(dout), 64'(words[9]));
    chk("drain10_empty", 64'(empty), 64'(1));

    // Fill to capacity, then one rejected push.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 32'hA000_0000 + DW'(i));
    chk("full_flag", 64'(full), 64'(1));
    step(1'b1, 1'b0, 32'hBAD0_0017);
    chk("ovf_pulse", 64'(overflow), 64'(1));
    step(1'b0, 1'b0, '0);
    chk("ovf_clear", 64'(overflow), 64'(0));
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0);
    chk("drain16_last", 64'(dout), 64'(32'hA000_000F));

    // Pop while empty: dout holds.
    step(1'b0, 1'b1, '0);
    chk("unf_pulse", 64'(underflow), 64'(1));
    chk("unf_dout_hold", 64'(dout), 64'(32'hA000_000F));
    step(1'b0, 1'b0, '0);

    // Simultaneous push+pop on empty, then on full.
    step(1'b1, 1'b1, 32'h5000_0000);
    chk("pp_empty_count", 64'(count), 64'(1));
    for (int i = 1; i < DEPTH; i++) step(1'b1, 1'b0, 32'h5000_0000 + DW'(i));
    step(1'b1, 1'b1, 32'hDEADBEEF);
    chk("pp_full_dout", 64'(dout), 64'(32'h5000_0000));
    chk("pp_full_count", 64'(count), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0);
    chk("deadbeef_last", 64'(dout), 64'(32'hDEADBEEF));

    // Steady traffic around half-full, crossing pointer wrap several times.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, $urandom);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, $urandom);
    chk("wrap_count", 64'(count), 64'(8));

    // Asynchronous reset between edges.
    #2;
    reset = 1'b1;
    #1;
    chk_reset_state("rst_mid");
    sb.delete();
    m_dout = '0;
    #1;
    reset = 1'b0;
    step(1'b0, 1'b1, '0);
    step(1'b1, 1'b0, 32'h0BAD_F00D);
    step(1'b0, 1'b1, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
